mem_issue_pipe: RTL and testbench

- Two-stage issue pipeline placed directly after the memory issue queue. Covers stages i1 (register-file read) and i2 (bypass, operand capture, hand-off to the LSU).
- Per port, consumes the queue's registered select output (can_issue + issueState_t).
- Returns the i2 feedback to the queue: issueSuccess or issueReplay, plus the entry index.
- Also drives the fu_busy back-pressure into the queue's select.

---
 rtl/mem_issue_pipe_if.sv | 64 ++++++
 rtl/mem_issue_pipe.sv | 161 ++++++++++++++++
 tb/tb_mem_issue_pipe.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_issue_pipe_if.sv
// Bundle between the memory issue queue/LSU side (master) and the i1/i2 issue pipe (slave).
// MEM_ISSUE_PERF_EN adds the per-port performance counter outputs.
interface mem_issue_pipe_if #(
   parameter int NPORT   = 2,
   parameter int NBYP    = 4,
   parameter int NLDC    = 2,
   parameter int XLEN    = 64,
   parameter int IQDEPTH = 8,
   parameter int IPRW    = 7
);
   localparam int IQW = $clog2(IQDEPTH);

   typedef struct packed {
      logic [IQW-1:0]       iqIdx;
      logic                 useImm;
      logic [31:0]          imm;
      logic [1:0][IPRW-1:0] iprs;
   } issueState_t;

   logic                            flush_i;
   logic [NPORT-1:0]                iss_vld_i;
   issueState_t [NPORT-1:0]         iss_state_i;
   logic [NPORT-1:0]                fu_busy_o;
   logic [NPORT-1:0][1:0]           rf_ren_o;
   logic [NPORT-1:0][1:0][IPRW-1:0] rf_ridx_o;
   logic [NPORT-1:0][1:0][XLEN-1:0] rf_rdata_i;
   logic [NBYP-1:0]                 byp_vld_i;
   logic [NBYP-1:0][IPRW-1:0]       byp_iprd_i;
   logic [NBYP-1:0][XLEN-1:0]       byp_data_i;
   logic [NLDC-1:0]                 ldc_vld_i;
   logic [NLDC-1:0][IPRW-1:0]       ldc_iprd_i;
   logic [NPORT-1:0]                fu_vld_o;
   logic [NPORT-1:0]                fu_rdy_i;
   issueState_t [NPORT-1:0]         fu_state_o;
   logic [NPORT-1:0][1:0][XLEN-1:0] fu_src_o;
   logic [NPORT-1:0]                issueSuccess_o;
   logic [NPORT-1:0]                issueReplay_o;
   logic [NPORT-1:0][IQW-1:0]       feedbackIdx_o;
`ifdef MEM_ISSUE_PERF_EN
   logic [NPORT-1:0][31:0]          perf_issue_o;
   logic [NPORT-1:0][31:0]          perf_replay_cancel_o;
   logic [NPORT-1:0][31:0]          perf_replay_busy_o;
`endif

   modport master (
      output flush_i, iss_vld_i, iss_state_i, rf_rdata_i, byp_vld_i, byp_iprd_i, byp_data_i,
             ldc_vld_i, ldc_iprd_i, fu_rdy_i,
      input  fu_busy_o, rf_ren_o, rf_ridx_o, fu_vld_o, fu_state_o, fu_src_o,
             issueSuccess_o, issueReplay_o, feedbackIdx_o
`ifdef MEM_ISSUE_PERF_EN
      , input perf_issue_o, perf_replay_cancel_o, perf_replay_busy_o
`endif
   );

   modport slave (
      input  flush_i, iss_vld_i, iss_state_i, rf_rdata_i, byp_vld_i, byp_iprd_i, byp_data_i,
             ldc_vld_i, ldc_iprd_i, fu_rdy_i,
      output fu_busy_o, rf_ren_o, rf_ridx_o, fu_vld_o, fu_state_o, fu_src_o,
             issueSuccess_o, issueReplay_o, feedbackIdx_o
`ifdef MEM_ISSUE_PERF_EN
      , output perf_issue_o, perf_replay_cancel_o, perf_replay_busy_o
`endif
   );
endinterface

// File: rtl/mem_issue_pipe.sv
// Two-stage memory issue pipe: i1 regfile read, i2 bypass/operand capture, LSU hand-off and queue feedback.
// Define MEM_ISSUE_PERF_EN to add per-port saturating issue/replay counters.
module mem_issue_pipe #(
   parameter int NPORT   = 2,
   parameter int NBYP    = 4,
   parameter int NLDC    = 2,
   parameter int XLEN    = 64,
   parameter int IQDEPTH = 8,
   parameter int IPRW    = 7
) (
   input logic             clk,
   input logic             rst,
   mem_issue_pipe_if.slave bus
);
   localparam int IQW = $clog2(IQDEPTH);

   // Bit layout must stay identical to issueState_t in mem_issue_pipe_if.
   typedef struct packed {
      logic [IQW-1:0]       iqIdx;
      logic                 useImm;
      logic [31:0]          imm;
      logic [1:0][IPRW-1:0] iprs;
   } issueState_t;

   logic [NPORT-1:0]                s1_vld_q, s1_vld_d;
   logic [NPORT-1:0]                s2_vld_q, s2_vld_d;
   logic [NPORT-1:0]                s2_cncl_q, s2_cncl_d;
   logic [NPORT-1:0]                fu_busy_q, fu_busy_d;
   issueState_t [NPORT-1:0]         s1_state_q, s2_state_q;

   logic [NPORT-1:0]                s1_cncl, s2_cncl;
   logic [NPORT-1:0]                fu_vld, fb_ok, fb_rep;
   logic [NPORT-1:0][1:0]           rf_ren;
   logic [NPORT-1:0][1:0][IPRW-1:0] rf_ridx;
   logic [NPORT-1:0][1:0][XLEN-1:0] fu_src;
   logic [NPORT-1:0][IQW-1:0]       fb_idx;
   logic                            kill;

   function automatic logic ldc_hit(input issueState_t st,
                                    input logic [NLDC-1:0] vld,
                                    input logic [NLDC-1:0][IPRW-1:0] iprd);
      logic hit;
      hit = 1'b0;
      for (int c = 0; c < NLDC; c++) begin
         if (vld[c] && ((iprd[c] == st.iprs[0]) || (!st.useImm && (iprd[c] == st.iprs[1]))))
            hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic [XLEN-1:0] pick_operand(input logic [IPRW-1:0] src,
                                                    input logic [XLEN-1:0] rf_data,
                                                    input logic [NBYP-1:0] vld,
                                                    input logic [NBYP-1:0][IPRW-1:0] iprd,
                                                    input logic [NBYP-1:0][XLEN-1:0] data);
      logic [XLEN-1:0] res;
      logic            found;
      res   = rf_data;
      found = 1'b0;
      for (int b = 0; b < NBYP; b++) begin
         if (!found && vld[b] && (iprd[b] == src)) begin
            res   = data[b];
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // Reset kills the i2 outputs in the same cycle, like flush, so no feedback escapes.
   assign kill = bus.flush_i | rst;

   always_comb begin
      s1_vld_d  = bus.iss_vld_i & {NPORT{~bus.flush_i}};
      s2_vld_d  = s1_vld_q & {NPORT{~bus.flush_i}};
      s1_cncl   = '0;
      s2_cncl   = '0;
      fu_vld    = '0;
      fb_ok     = '0;
      fb_rep    = '0;
      fu_busy_d = '0;
      rf_ren    = '0;
      rf_ridx   = '0;
      fu_src    = '0;
      fb_idx    = '0;
      for (int p = 0; p < NPORT; p++) begin
         s1_cncl[p]    = s1_vld_q[p] & ldc_hit(s1_state_q[p], bus.ldc_vld_i, bus.ldc_iprd_i);
         s2_cncl[p]    = s2_cncl_q[p] | ldc_hit(s2_state_q[p], bus.ldc_vld_i, bus.ldc_iprd_i);
         rf_ren[p][0]  = s1_vld_q[p];
         rf_ren[p][1]  = s1_vld_q[p] & ~s1_state_q[p].useImm;
         rf_ridx[p][0] = s1_state_q[p].iprs[0];
         rf_ridx[p][1] = s1_state_q[p].iprs[1];

         fu_vld[p]    = s2_vld_q[p] & ~s2_cncl[p] & ~kill;
         fb_ok[p]     = fu_vld[p] & bus.fu_rdy_i[p];
         fb_rep[p]    = s2_vld_q[p] & ~kill & (s2_cncl[p] | ~bus.fu_rdy_i[p]);
         fu_busy_d[p] = s2_vld_q[p] & fu_vld[p] & ~bus.fu_rdy_i[p];
         fb_idx[p]    = s2_state_q[p].iqIdx;

         fu_src[p][0] = pick_operand(s2_state_q[p].iprs[0], bus.rf_rdata_i[p][0],
                                     bus.byp_vld_i, bus.byp_iprd_i, bus.byp_data_i);
         if (s2_state_q[p].useImm)
            fu_src[p][1] = {{(XLEN-32){s2_state_q[p].imm[31]}}, s2_state_q[p].imm};
         else
            fu_src[p][1] = pick_operand(s2_state_q[p].iprs[1], bus.rf_rdata_i[p][1],
                                        bus.byp_vld_i, bus.byp_iprd_i, bus.byp_data_i);
      end
      s2_cncl_d = s1_cncl;
   end

   // State payload is don't-care while invalid, so it is loaded unconditionally.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= '0;
         s2_vld_q  <= '0;
         s2_cncl_q <= '0;
         fu_busy_q <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s2_vld_q  <= s2_vld_d;
         s2_cncl_q <= s2_cncl_d;
         fu_busy_q <= fu_busy_d;
      end
      s1_state_q <= bus.iss_state_i;
      s2_state_q <= s1_state_q;
   end

   assign bus.fu_busy_o      = fu_busy_q;
   assign bus.rf_ren_o       = rf_ren;
   assign bus.rf_ridx_o      = rf_ridx;
   assign bus.fu_vld_o       = fu_vld;
   assign bus.fu_state_o     = s2_state_q;
   assign bus.fu_src_o       = fu_src;
   assign bus.issueSuccess_o = fb_ok;
   assign bus.issueReplay_o  = fb_rep;
   assign bus.feedbackIdx_o  = fb_idx;

`ifdef MEM_ISSUE_PERF_EN
   logic [NPORT-1:0][31:0] perf_iss_q, perf_rc_q, perf_rb_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_iss_q <= '0;
         perf_rc_q  <= '0;
         perf_rb_q  <= '0;
      end else begin
         for (int p = 0; p < NPORT; p++) begin
            if (fb_ok[p] && (perf_iss_q[p] != 32'hFFFF_FFFF))
               perf_iss_q[p] <= perf_iss_q[p] + 32'd1;
            if (fb_rep[p] && s2_cncl[p] && (perf_rc_q[p] != 32'hFFFF_FFFF))
               perf_rc_q[p] <= perf_rc_q[p] + 32'd1;
            if (fb_rep[p] && !s2_cncl[p] && (perf_rb_q[p] != 32'hFFFF_FFFF))
               perf_rb_q[p] <= perf_rb_q[p] + 32'd1;
         end
      end
   end

   assign bus.perf_issue_o         = perf_iss_q;
   assign bus.perf_replay_cancel_o = perf_rc_q;
   assign bus.perf_replay_busy_o   = perf_rb_q;
`endif
endmodule

// File: tb/tb_mem_issue_pipe.sv
// Directed bench for mem_issue_pipe: issue, bypass priority, load cancel, stall, flush, reset.
module tb_mem_issue_pipe;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   mem_issue_pipe_if bus ();

   mem_issue_pipe dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush_i     = 1'b0;
      bus.iss_vld_i   = '0;
      bus.iss_state_i = '0;
      bus.rf_rdata_i  = '0;
      bus.byp_vld_i   = '0;
      bus.byp_iprd_i  = '0;
      bus.byp_data_i  = '0;
      bus.ldc_vld_i   = '0;
      bus.ldc_iprd_i  = '0;
      bus.fu_rdy_i    = '1;
   endtask

   task automatic issue(input int p, input int iq, input int r0, input int r1,
                        input logic ui, input logic [31:0] imm);
      bus.iss_vld_i[p]             = 1'b1;
      bus.iss_state_i[p].iqIdx     = 3'(iq);
      bus.iss_state_i[p].useImm    = ui;
      bus.iss_state_i[p].imm       = imm;
      bus.iss_state_i[p].iprs[0]   = 7'(r0);
      bus.iss_state_i[p].iprs[1]   = 7'(r1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      idle();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      #1;
      chk("rst_fu_vld", bus.fu_vld_o, 0);
      chk("rst_busy",   bus.fu_busy_o, 0);
      chk("rst_succ",   bus.issueSuccess_o, 0);
      chk("rst_repl",   bus.issueReplay_o, 0);
      chk("rst_rf_ren", bus.rf_ren_o, 0);

      // basic issue on port 0
      issue(0, 3, 5, 6, 1'b0, 32'h0);
      step(); bus.iss_vld_i = '0; #1;
      chk("t1_rf_ren", bus.rf_ren_o[0], 2'b11);
      chk("t1_ridx0",  bus.rf_ridx_o[0][0], 5);
      chk("t1_ridx1",  bus.rf_ridx_o[0][1], 6);
      chk("t1_fu_vld_early", bus.fu_vld_o, 0);
      step(); bus.rf_rdata_i[0][0] = 64'h11; bus.rf_rdata_i[0][1] = 64'h22; #1;
      chk("t2_fu_vld", bus.fu_vld_o, 2'b01);
      chk("t2_src0",   bus.fu_src_o[0][0], 64'h11);
      chk("t2_src1",   bus.fu_src_o[0][1], 64'h22);
      chk("t2_succ",   bus.issueSuccess_o, 2'b01);
      chk("t2_repl",   bus.issueReplay_o, 2'b00);
      chk("t2_fbidx",  bus.feedbackIdx_o[0], 3);
      chk("t2_state",  bus.fu_state_o[0].iqIdx, 3);
      step(); bus.rf_rdata_i = '0; #1;
      chk("t3_drain", bus.fu_vld_o, 0);
      chk("t3_busy",  bus.fu_busy_o, 0);

      // bypass priority: lowest valid matching source wins
      issue(0, 2, 5, 6, 1'b0, 32'h0);
      step(); bus.iss_vld_i = '0;
      step();
      bus.rf_rdata_i[0][0] = 64'h11; bus.rf_rdata_i[0][1] = 64'h22;
      bus.byp_vld_i     = 4'b0110;
      bus.byp_iprd_i[0] = 7'd6; bus.byp_data_i[0] = 64'hCC;
      bus.byp_iprd_i[1] = 7'd6; bus.byp_data_i[1] = 64'hAA;
      bus.byp_iprd_i[2] = 7'd6; bus.byp_data_i[2] = 64'hBB;
      bus.byp_iprd_i[3] = 7'd5; bus.byp_data_i[3] = 64'hDD;
      #1;
      chk("byp_src1", bus.fu_src_o[0][1], 64'hAA);
      chk("byp_src0", bus.fu_src_o[0][0], 64'h11);
      chk("byp_succ", bus.issueSuccess_o, 2'b01);
      bus.byp_vld_i = 4'b1000; #1;
      chk("byp3_src0", bus.fu_src_o[0][0], 64'hDD);
      chk("byp3_src1", bus.fu_src_o[0][1], 64'h22);
      step(); idle();

      // load cancel while in s1
      issue(0, 4, 5, 6, 1'b0, 32'h0);
      step(); bus.iss_vld_i = '0; bus.ldc_vld_i = 2'b01; bus.ldc_iprd_i[0] = 7'd5;
      step(); bus.ldc_vld_i = '0; #1;
      chk("ldc1_fu_vld", bus.fu_vld_o, 0);
      chk("ldc1_repl",   bus.issueReplay_o, 2'b01);
      chk("ldc1_succ",   bus.issueSuccess_o, 0);
      chk("ldc1_fbidx",  bus.feedbackIdx_o[0], 4);
      step(); #1;
      chk("ldc1_busy", bus.fu_busy_o, 0);
      chk("ldc1_repl_gone", bus.issueReplay_o, 0);

      // load cancel on src1 while in s2, port 1
      issue(1, 5, 8, 9, 1'b0, 32'h0);
      step(); bus.iss_vld_i = '0;
      step(); bus.ldc_vld_i = 2'b10; bus.ldc_iprd_i[1] = 7'd9; #1;
      chk("ldc2_fu_vld", bus.fu_vld_o, 0);
      chk("ldc2_repl",   bus.issueReplay_o, 2'b10);
      chk("ldc2_succ",   bus.issueSuccess_o, 0);
      step(); idle();

      // immediate: src1 from imm, no read, not cancelled by unused iprs[1]
      issue(0, 1, 12, 13, 1'b1, 32'hFFFF_FFF0);
      step(); bus.iss_vld_i = '0; #1;
      chk("imm_rf_ren", bus.rf_ren_o[0], 2'b01);
      step(); bus.ldc_vld_i = 2'b01; bus.ldc_iprd_i[0] = 7'd13; bus.rf_rdata_i[0][0] = 64'h55; #1;
      chk("imm_fu_vld", bus.fu_vld_o, 2'b01);
      chk("imm_src0",   bus.fu_src_o[0][0], 64'h55);
      chk("imm_src1",   bus.fu_src_o[0][1], 64'hFFFF_FFFF_FFFF_FFF0);
      chk("imm_succ",   bus.issueSuccess_o, 2'b01);
      step(); idle();

      // FU stall on port 1
      issue(1, 7, 10, 11, 1'b0, 32'h0);
      step(); bus.iss_vld_i = '0;
      step(); bus.fu_rdy_i = 2'b01; #1;
      chk("stall_fu_vld", bus.fu_vld_o, 2'b10);
      chk("stall_repl",   bus.issueReplay_o, 2'b10);
      chk("stall_succ",   bus.issueSuccess_o, 0);
      chk("stall_fbidx",  bus.feedbackIdx_o[1], 7);
      step(); bus.fu_rdy_i = '1; #1;
      chk("stall_busy",  bus.fu_busy_o, 2'b10);
      chk("stall_repl2", bus.issueReplay_o, 0);
      step(); #1;
      chk("stall_busy_clr", bus.fu_busy_o, 0);

      // back-to-back on both ports
      issue(0, 1, 1, 2, 1'b0, 32'h0); issue(1, 2, 3, 4, 1'b0, 32'h0);
      step();
      issue(0, 3, 1, 2, 1'b0, 32'h0); issue(1, 4, 3, 4, 1'b0, 32'h0);
      step(); bus.iss_vld_i = '0; #1;
      chk("b2b_succ_a",  bus.issueSuccess_o, 2'b11);
      chk("b2b_fbidx_a", bus.feedbackIdx_o, {3'd2, 3'd1});
      step(); #1;
      chk("b2b_succ_b",  bus.issueSuccess_o, 2'b11);
      chk("b2b_fbidx_b", bus.feedbackIdx_o, {3'd4, 3'd3});
      step(); #1;
      chk("b2b_empty", bus.fu_vld_o, 0);

      // flush with ops in s1 and s2 and a new op arriving
      issue(0, 1, 1, 2, 1'b0, 32'h0); issue(1, 2, 3, 4, 1'b0, 32'h0);
      step();
      issue(0, 3, 1, 2, 1'b0, 32'h0); issue(1, 4, 3, 4, 1'b0, 32'h0);
      step();
      issue(0, 5, 1, 2, 1'b0, 32'h0); issue(1, 6, 3, 4, 1'b0, 32'h0);
      bus.flush_i = 1'b1; #1;
      chk("fl_fu_vld", bus.fu_vld_o, 0);
      chk("fl_succ",   bus.issueSuccess_o, 0);
      chk("fl_repl",   bus.issueReplay_o, 0);
      step(); bus.flush_i = 1'b0; bus.iss_vld_i = '0; #1;
      chk("fl_rf_ren",  bus.rf_ren_o, 0);
      chk("fl_fu_vld2", bus.fu_vld_o, 0);
      chk("fl_fb2",     {bus.issueSuccess_o, bus.issueReplay_o}, 0);
      step(); #1;
      chk("fl_fu_vld3", bus.fu_vld_o, 0);
      chk("fl_fb3",     {bus.issueSuccess_o, bus.issueReplay_o}, 0);
      issue(0, 2, 20, 21, 1'b0, 32'h0);
      step(); bus.iss_vld_i = '0;
      step(); bus.rf_rdata_i[0][0] = 64'h77; bus.rf_rdata_i[0][1] = 64'h88; #1;
      chk("fl_new_succ",  bus.issueSuccess_o, 2'b01);
      chk("fl_new_fbidx", bus.feedbackIdx_o[0], 2);
      chk("fl_new_src0",  bus.fu_src_o[0][0], 64'h77);
      step(); idle();

      // reset with a stalled op in s2
      issue(0, 6, 30, 31, 1'b0, 32'h0);
      step(); bus.iss_vld_i = '0;
      step(); bus.fu_rdy_i = 2'b00; rst = 1'b1; #1;
      chk("rs_fu_vld", bus.fu_vld_o, 0);
      chk("rs_repl",   bus.issueReplay_o, 0);
      chk("rs_succ",   bus.issueSuccess_o, 0);
      step(); rst = 1'b0; bus.fu_rdy_i = '1; #1;
      chk("rs_busy",   bus.fu_busy_o, 0);
      chk("rs_fu_vld2", bus.fu_vld_o, 0);
      chk("rs_fb2",    {bus.issueSuccess_o, bus.issueReplay_o}, 0);
      chk("rs_rf_ren", bus.rf_ren_o, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
